// File: rtl/seq_chunk_adder_if.sv
// Handshake bundle for seq_chunk_adder: operand request channel and result channel.
// The producer/consumer side uses the master modport and the adder uses the slave modport.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: adds a WIDTH-bit operand pair CHUNK bits per clock,
// with a registered inter-chunk carry, valid/ready handshakes and a signed overflow flag.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              reset,
    seq_chunk_adder_if.slave  bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_a_k;
    logic [CHUNK-1:0] w_b_k;
    logic [CHUNK:0]   w_full;

    // Current chunk slice and its sum including the carry from the previous chunk.
    assign w_base = 32'(r_cnt) * 32'(CHUNK);
    assign w_a_k  = CHUNK'(r_a >> w_base);
    assign w_b_k  = CHUNK'(r_b >> w_base);
    assign w_full = {1'b0, w_a_k} + {1'b0, w_b_k} + (CHUNK+1)'(r_carry);
    assign w_last = (r_cnt == CW'(N - 1));

    // Next-state and accept decode for the IDLE -> RUN -> HOLD -> IDLE sequence.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_next_state = S_RUN;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_HOLD;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_HOLD;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register; handshake flags are registered from the next state so they never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state == S_IDLE);
            r_out_valid <= (w_next_state == S_HOLD);
            r_busy      <= (w_next_state != S_IDLE);
        end
    end

    // Operand capture on accept, then one chunk per RUN cycle; subtraction uses ~b and ~cin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? ~bus.cin : bus.cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == S_RUN) begin
            // Sum is cleared on accept, so OR-ing each chunk into place is exact.
            r_sum   <= r_sum | (WIDTH'(w_full[CHUNK-1:0]) << w_base);
            r_carry <= w_full[CHUNK];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_cout <= w_full[CHUNK];
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                          (w_full[CHUNK-1] != r_a[WIDTH-1]);
            end else begin
                r_cout <= r_cout;
                r_ovf  <= r_ovf;
            end
        end else begin
            r_sum   <= r_sum;
            r_carry <= r_carry;
            r_cnt   <= r_cnt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Randomized self-checking bench for seq_chunk_adder (CHUNK=4 and CHUNK=16 instances)
// against an integer-arithmetic reference model.
module tb_seq_chunk_adder;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    seq_chunk_adder_if #(.WIDTH(16)) bus  ();
    seq_chunk_adder_if #(.WIDTH(16)) bus2 ();

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  dut  (.clk(clk), .reset(reset), .bus(bus));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} from plain signed/unsigned integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        int u, r, sa, sb;
        logic [15:0] s;
        logic c, o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!sub) begin
            u = int'(a) + int'(b) + int'(cin);
            c = (u > 65535);
            r = sa + sb + int'(cin);
        end else begin
            u = int'(a) - int'(b) - int'(cin);
            c = (u >= 0);
            r = sa - sb - int'(cin);
        end
        s = u[15:0];
        o = (r > 32767) || (r < -32768);
        return {o, c, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input int hold);
        int g;
        int lat;
        logic [17:0] exp;
        exp = model(a, b, cin, sub);
        g = 0;
        while (!bus.in_ready && g < 50) begin
            tick();
            g++;
        end
        if (g >= 50) check_eq("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        bus.cin = 1'($urandom); bus.sub = 1'($urandom);
        check_eq("in_ready_run", 32'(bus.in_ready), 32'd0);
        check_eq("busy_run", 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("latency", 32'(lat), 32'd4);
        check_eq("sum", 32'(bus.sum), 32'(exp[15:0]));
        check_eq("cout", 32'(bus.cout), 32'(exp[16]));
        check_eq("ovf", 32'(bus.ovf), 32'(exp[17]));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            tick();
            check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("hold_sum", 32'(bus.sum), 32'(exp[15:0]));
            check_eq("hold_busy", 32'(bus.busy), 32'd1);
        end
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("release_valid", 32'(bus.out_valid), 32'd0);
        check_eq("release_ready", 32'(bus.in_ready), 32'd1);
        check_eq("release_busy", 32'(bus.busy), 32'd0);
    endtask

    logic [15:0] dir_a   [7] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0000, 16'hFFFF};
    logic [15:0] dir_b   [7] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000, 16'hFFFF};
    logic        dir_cin [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        dir_sub [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        logic [17:0] exp2;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
        bus.cin = 1'b0; bus.sub = 1'b0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.a = '0; bus2.b = '0;
        bus2.cin = 1'b0; bus2.sub = 1'b0;
        tick();
        tick();
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_sum", 32'(bus.sum), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_op(dir_a[i], dir_b[i], dir_cin[i], dir_sub[i], 3);

        // Abort an operation two cycles into RUN.
        bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_sum", 32'(bus.sum), 32'd0);
        check_eq("abort_cout", 32'(bus.cout), 32'd0);
        check_eq("abort_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("abort_no_result", 32'(bus.out_valid), 32'd0);
        end
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));

        // Single-chunk instance: latency of one cycle.
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                bus2.a = 16'hAAAA; bus2.b = 16'h5555; bus2.cin = 1'b1; bus2.sub = 1'b0;
            end else begin
                bus2.a = 16'($urandom); bus2.b = 16'($urandom);
                bus2.cin = 1'($urandom); bus2.sub = 1'($urandom);
            end
            exp2 = model(bus2.a, bus2.b, bus2.cin, bus2.sub);
            bus2.in_valid = 1'b1;
            tick();
            bus2.in_valid = 1'b0;
            check_eq("c16_in_ready", 32'(bus2.in_ready), 32'd0);
            tick();
            check_eq("c16_valid", 32'(bus2.out_valid), 32'd1);
            check_eq("c16_sum", 32'(bus2.sum), 32'(exp2[15:0]));
            check_eq("c16_cout", 32'(bus2.cout), 32'(exp2[16]));
            check_eq("c16_ovf", 32'(bus2.ovf), 32'(exp2[17]));
            bus2.out_ready = 1'b1;
            tick();
            bus2.out_ready = 1'b0;
            check_eq("c16_release", 32'(bus2.out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
